// File: rtl/ctrl_pkg.sv
// Shared control-path constants: opcodes, functs, ALU codes,
// bundle field layout and divider FSM states.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [4:0] {
        ALU_NOP  = 5'd0,
        ALU_ADD  = 5'd1,
        ALU_SUB  = 5'd2,
        ALU_AND  = 5'd3,
        ALU_OR   = 5'd4,
        ALU_SLT  = 5'd5,
        ALU_DIV  = 5'd6,
        ALU_DIVU = 5'd7
    } alu_op_e;

    // Bundle, MSB first: {memtoreg, memwrite, alusrc, regdst,
    // regwrite, alucontrol, div}. Flag offsets sit above alucontrol.
    localparam int F_DIV       = 0;
    localparam int F_ALUC      = 1;
    localparam int FO_REGWRITE = 0;
    localparam int FO_REGDST   = 1;
    localparam int FO_ALUSRC   = 2;
    localparam int FO_MEMWRITE = 3;
    localparam int FO_MEMTOREG = 4;
    localparam int FLAG_BITS   = 5;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/ctrl_stage_reg.sv
// Generic pipeline stage register: async reset, hold when
// disabled, synchronous clear that wins over hold.
module ctrl_stage_reg
    import ctrl_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ctrl_pipeline.sv
// Main decoder, E/M/W control stage registers and the
// multi-cycle divider sequencer.
module ctrl_pipeline
    import ctrl_pkg::*;
#(
    parameter int ALUC_W     = 5,
    parameter int DIV_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instrD,
    input  logic              equalD,
    input  logic              stallE,
    input  logic              stallM,
    input  logic              stallW,
    input  logic              flushE,
    input  logic              flushM,
    input  logic              flushW,
    output logic              pcsrcD,
    output logic              branchD,
    output logic              jumpD,
    output logic              is_IMM,
    output logic              memtoregE,
    output logic              alusrcE,
    output logic              regdstE,
    output logic              regwriteE,
    output logic [ALUC_W-1:0] alucontrolE,
    output logic              memtoregM,
    output logic              memwriteM,
    output logic              regwriteM,
    output logic              memtoregW,
    output logic              regwriteW,
    output logic              div_stall,
    output logic              div_done
);

    localparam int BW = ALUC_W + FLAG_BITS + 1;
    localparam int FB = ALUC_W + 1;
    localparam int CW = $clog2(DIV_CYCLES);

    logic [5:0] op;
    logic [5:0] fn;
    logic       unused_instr;

    assign op = instrD[31:26];
    assign fn = instrD[5:0];
    assign unused_instr = ^instrD[25:6];

    logic              memtoreg;
    logic              memwrite;
    logic              alusrc;
    logic              regdst;
    logic              regwrite;
    logic              div;
    logic [ALUC_W-1:0] aluc;

    always_comb begin
        memtoreg = 1'b0;
        memwrite = 1'b0;
        alusrc   = 1'b0;
        regdst   = 1'b0;
        regwrite = 1'b0;
        div      = 1'b0;
        aluc     = '0;
        branchD  = 1'b0;
        jumpD    = 1'b0;
        is_IMM   = 1'b0;
        unique case (1'b1)
            op == OP_RTYPE: begin
                unique case (1'b1)
                    fn == FN_ADD: begin
                        regdst = 1'b1; regwrite = 1'b1;
                        aluc = ALUC_W'(ALU_ADD);
                    end
                    fn == FN_SUB: begin
                        regdst = 1'b1; regwrite = 1'b1;
                        aluc = ALUC_W'(ALU_SUB);
                    end
                    fn == FN_AND: begin
                        regdst = 1'b1; regwrite = 1'b1;
                        aluc = ALUC_W'(ALU_AND);
                    end
                    fn == FN_OR: begin
                        regdst = 1'b1; regwrite = 1'b1;
                        aluc = ALUC_W'(ALU_OR);
                    end
                    fn == FN_SLT: begin
                        regdst = 1'b1; regwrite = 1'b1;
                        aluc = ALUC_W'(ALU_SLT);
                    end
                    fn == FN_DIV: begin
                        div = 1'b1;
                        aluc = ALUC_W'(ALU_DIV);
                    end
                    fn == FN_DIVU: begin
                        div = 1'b1;
                        aluc = ALUC_W'(ALU_DIVU);
                    end
                    default: ;
                endcase
            end
            op == OP_LW: begin
                memtoreg = 1'b1; alusrc = 1'b1; regwrite = 1'b1;
                aluc = ALUC_W'(ALU_ADD);
            end
            op == OP_SW: begin
                memwrite = 1'b1; alusrc = 1'b1;
                aluc = ALUC_W'(ALU_ADD);
            end
            op == OP_BEQ: begin
                branchD = 1'b1;
                aluc = ALUC_W'(ALU_SUB);
            end
            op == OP_J: begin
                jumpD = 1'b1;
            end
            op == OP_ADDI: begin
                alusrc = 1'b1; regwrite = 1'b1; is_IMM = 1'b1;
                aluc = ALUC_W'(ALU_ADD);
            end
            op == OP_ANDI: begin
                alusrc = 1'b1; regwrite = 1'b1; is_IMM = 1'b1;
                aluc = ALUC_W'(ALU_AND);
            end
            op == OP_ORI: begin
                alusrc = 1'b1; regwrite = 1'b1; is_IMM = 1'b1;
                aluc = ALUC_W'(ALU_OR);
            end
            op == OP_SLTI: begin
                alusrc = 1'b1; regwrite = 1'b1; is_IMM = 1'b1;
                aluc = ALUC_W'(ALU_SLT);
            end
            default: ;
        endcase
    end

    assign pcsrcD = branchD & equalD;

    logic [BW-1:0] bundle_d;
    logic [BW-1:0] bundle_e;
    logic [BW-1:0] bundle_m;
    logic [BW-1:0] bundle_w;

    assign bundle_d = {memtoreg, memwrite, alusrc, regdst,
                       regwrite, aluc, div};

    ctrl_stage_reg #(.W(BW)) u_reg_e (
        .clk (clk),
        .rst (rst),
        .en  (~stallE),
        .clr (flushE),
        .d   (bundle_d),
        .q   (bundle_e)
    );

    ctrl_stage_reg #(.W(BW)) u_reg_m (
        .clk (clk),
        .rst (rst),
        .en  (~stallM),
        .clr (flushM),
        .d   (bundle_e),
        .q   (bundle_m)
    );

    ctrl_stage_reg #(.W(BW)) u_reg_w (
        .clk (clk),
        .rst (rst),
        .en  (~stallW),
        .clr (flushW),
        .d   (bundle_m),
        .q   (bundle_w)
    );

    assign memtoregE   = bundle_e[FB + FO_MEMTOREG];
    assign alusrcE     = bundle_e[FB + FO_ALUSRC];
    assign regdstE     = bundle_e[FB + FO_REGDST];
    assign regwriteE   = bundle_e[FB + FO_REGWRITE];
    assign alucontrolE = bundle_e[F_ALUC +: ALUC_W];
    assign memtoregM   = bundle_m[FB + FO_MEMTOREG];
    assign memwriteM   = bundle_m[FB + FO_MEMWRITE];
    assign regwriteM   = bundle_m[FB + FO_REGWRITE];
    assign memtoregW   = bundle_w[FB + FO_MEMTOREG];
    assign regwriteW   = bundle_w[FB + FO_REGWRITE];

    logic          unused_bundle;
    logic          div_e;
    div_state_e    state;
    div_state_e    state_n;
    logic [CW-1:0] count;
    logic [CW-1:0] count_n;
    logic          done_seen;

    assign div_e = bundle_e[F_DIV];
    assign unused_bundle = ^{bundle_m[FB + FO_ALUSRC +: 2],
                             bundle_m[FB-1:0], bundle_w[FB + FO_ALUSRC +: 3],
                             bundle_w[FB-1:0], bundle_e[FB + FO_MEMWRITE]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= DIV_IDLE;
            count     <= '0;
            done_seen <= 1'b0;
        end else begin
            state     <= state_n;
            count     <= count_n;
            done_seen <= (state == DIV_DONE);
        end
    end

    // DONE lingers while E is held so the same divide cannot retrigger.
    always_comb begin
        state_n   = state;
        count_n   = count;
        div_stall = 1'b0;
        div_done  = 1'b0;
        unique case (state)
            DIV_IDLE: begin
                if (div_e && !flushE) begin
                    state_n = DIV_BUSY;
                    count_n = CW'(DIV_CYCLES - 1);
                end
            end
            DIV_BUSY: begin
                div_stall = 1'b1;
                if (flushE) begin
                    state_n = DIV_IDLE;
                    count_n = '0;
                end else if (count == '0) begin
                    state_n = DIV_DONE;
                end else begin
                    count_n = count - CW'(1);
                end
            end
            DIV_DONE: begin
                div_done = ~done_seen;
                if (!stallE) begin
                    state_n = DIV_IDLE;
                end
            end
            default: begin
                state_n = DIV_IDLE;
                count_n = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed bench for ctrl_pipeline: decode, stage rules,
// and divider sequencing with DIV_CYCLES=4.
module tb_ctrl_pipeline;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instrD;
    logic        equalD;
    logic        stallE, stallM, stallW;
    logic        flushE, flushM, flushW;
    logic        pcsrcD, branchD, jumpD, is_IMM;
    logic        memtoregE, alusrcE, regdstE, regwriteE;
    logic [4:0]  alucontrolE;
    logic        memtoregM, memwriteM, regwriteM;
    logic        memtoregW, regwriteW;
    logic        div_stall, div_done;

    int checks = 0;
    int errors = 0;

    ctrl_pipeline #(.ALUC_W(5), .DIV_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .instrD      (instrD),
        .equalD      (equalD),
        .stallE      (stallE),
        .stallM      (stallM),
        .stallW      (stallW),
        .flushE      (flushE),
        .flushM      (flushM),
        .flushW      (flushW),
        .pcsrcD      (pcsrcD),
        .branchD     (branchD),
        .jumpD       (jumpD),
        .is_IMM      (is_IMM),
        .memtoregE   (memtoregE),
        .alusrcE     (alusrcE),
        .regdstE     (regdstE),
        .regwriteE   (regwriteE),
        .alucontrolE (alucontrolE),
        .memtoregM   (memtoregM),
        .memwriteM   (memwriteM),
        .regwriteM   (regwriteM),
        .memtoregW   (memtoregW),
        .regwriteW   (regwriteW),
        .div_stall   (div_stall),
        .div_done    (div_done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    // b = {memtoreg, memwrite, alusrc, regdst, regwrite, aluc[4:0], div}
    typedef struct packed {
        logic [31:0] instr;
        logic [10:0] b;
    } vec_t;

    localparam logic [31:0] I_ADD = 32'h012A4020;
    localparam logic [31:0] I_LW  = 32'h8D090004;
    localparam logic [31:0] I_SW  = 32'hAD090004;
    localparam logic [31:0] I_BEQ = 32'h112A0003;
    localparam logic [31:0] I_DIV = 32'h012A001A;

    vec_t tbl [9] = '{
        '{I_ADD,          11'b000_11_00001_0},
        '{I_LW,           11'b101_01_00001_0},
        '{I_SW,           11'b011_00_00001_0},
        '{32'h012A4022,   11'b000_11_00010_0},
        '{32'h3529000F,   11'b001_01_00100_0},
        '{32'hFC000000,   11'b000_00_00000_0},
        '{32'h012A4001,   11'b000_00_00000_0},
        '{32'h012A402A,   11'b000_11_00101_0},
        '{I_BEQ,          11'b000_00_00010_0}
    };

    logic [10:0] q[$];

    function automatic logic [31:0] ev(input logic [10:0] b);
        return 32'({b[10], b[8], b[7], b[6], b[5:1]});
    endfunction

    function automatic logic [31:0] mv(input logic [10:0] b);
        return 32'({b[10], b[9], b[6]});
    endfunction

    function automatic logic [31:0] wv(input logic [10:0] b);
        return 32'({b[10], b[6]});
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_check(input int i);
        int n;
        n = q.size();
        chk($sformatf("sbE%0d", i),
            32'({memtoregE, alusrcE, regdstE, regwriteE, alucontrolE}),
            ev(q[n-1]));
        if (n >= 2)
            chk($sformatf("sbM%0d", i),
                32'({memtoregM, memwriteM, regwriteM}), mv(q[n-2]));
        if (n >= 3) begin
            chk($sformatf("sbW%0d", i),
                32'({memtoregW, regwriteW}), wv(q[n-3]));
        end
        if (n > 3) void'(q.pop_front());
    endtask

    function automatic logic [31:0] all_regs();
        return 32'({memtoregE, alusrcE, regdstE, regwriteE,
                    alucontrolE, memtoregM, memwriteM, regwriteM,
                    memtoregW, regwriteW, div_stall, div_done});
    endfunction

    int sc, dc, fs, fd;

    initial begin
        rst = 1'b1;
        instrD = 32'h0;
        equalD = 1'b0;
        {stallE, stallM, stallW} = 3'b000;
        {flushE, flushM, flushW} = 3'b000;
        #3;
        chk("reset_regs", all_regs(), 32'h0);
        chk("reset_dec", 32'({pcsrcD, branchD, jumpD, is_IMM}), 32'h0);
        tick();
        tick();
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            instrD = tbl[i].instr;
            q.push_back(tbl[i].b);
            tick();
            sb_check(i);
        end
        for (int i = 9; i < 11; i++) begin
            instrD = 32'h0;
            q.push_back(11'b0);
            tick();
            sb_check(i);
        end
        q.delete();

        instrD = I_BEQ;
        equalD = 1'b1;
        #1;
        chk("beq_taken", 32'({pcsrcD, branchD}), 32'b11);
        equalD = 1'b0;
        #1;
        chk("beq_not_taken", 32'({pcsrcD, branchD}), 32'b01);
        instrD = 32'h08000010;
        #1;
        chk("jump", 32'({jumpD, branchD, is_IMM}), 32'b100);
        instrD = 32'h3529000F;
        #1;
        chk("ori_imm", 32'(is_IMM), 32'h1);

        instrD = I_SW;
        flushE = 1'b1;
        stallE = 1'b1;
        tick();
        chk("sw_flushE", 32'({alusrcE, alucontrolE}), 32'h0);
        flushE = 1'b0;
        stallE = 1'b0;
        instrD = 32'h0;
        tick();
        chk("sw_flushM", 32'(memwriteM), 32'h0);

        instrD = I_SW;
        tick();
        chk("sw_E", 32'({alusrcE, alucontrolE}), 32'h21);
        instrD = I_ADD;
        tick();
        chk("sw_M", 32'({memwriteM, regwriteE}), 32'b11);
        stallM = 1'b1;
        instrD = 32'h0;
        tick();
        chk("stallM_hold", 32'({memwriteM, regwriteM, alucontrolE}),
            32'({1'b1, 1'b0, 5'd0}));
        flushM = 1'b1;
        tick();
        chk("flushM_prio", 32'({memwriteM, regwriteM}), 32'h0);
        stallM = 1'b0;
        flushM = 1'b0;

        instrD = I_LW;
        tick();
        stallE = 1'b1;
        instrD = I_ADD;
        tick();
        chk("stallE_hold", 32'({memtoregE, regdstE, memtoregM}), 32'b101);
        stallE = 1'b0;
        instrD = 32'h0;
        tick();
        chk("lw_W", 32'({memtoregW, regwriteW}), 32'b11);
        stallW = 1'b1;
        tick();
        chk("stallW_hold", 32'({memtoregW, memtoregM}), 32'b10);
        flushW = 1'b1;
        tick();
        chk("flushW_prio", 32'({memtoregW, regwriteW}), 32'h0);
        stallW = 1'b0;
        flushW = 1'b0;
        tick();

        instrD = I_DIV;
        tick();
        chk("div_E", 32'({alucontrolE, div_stall}), 32'({5'd6, 1'b0}));
        instrD = 32'h0;
        sc = 0; dc = 0; fs = -1; fd = -1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (div_stall) begin
                sc++;
                if (fs < 0) fs = k;
            end
            if (div_done) begin
                dc++;
                if (fd < 0) fd = k;
            end
        end
        chk("div_stall_cycles", 32'(sc), 32'd4);
        chk("div_done_pulses", 32'(dc), 32'd1);
        chk("div_done_pos", 32'(fd), 32'(fs + 4));
        chk("div_idle", 32'({div_stall, div_done}), 32'h0);

        instrD = I_DIV;
        tick();
        stallE = 1'b1;
        instrD = 32'h0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("hold_busy%0d", k), 32'(div_stall), 32'h1);
        end
        tick();
        chk("hold_done1", 32'({div_stall, div_done}), 32'b01);
        tick();
        chk("hold_done2", 32'({div_stall, div_done}), 32'b00);
        stallE = 1'b0;
        tick();
        chk("hold_release", 32'({div_stall, div_done, alucontrolE}), 32'h0);
        tick();
        chk("no_retrigger", 32'({div_stall, div_done}), 32'h0);

        instrD = I_DIV;
        tick();
        instrD = 32'h0;
        tick();
        tick();
        chk("abort_busy", 32'(div_stall), 32'h1);
        flushE = 1'b1;
        tick();
        flushE = 1'b0;
        chk("abort_idle", 32'({div_stall, div_done}), 32'h0);
        dc = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (div_done || div_stall) dc++;
        end
        chk("abort_quiet", 32'(dc), 32'h0);

        instrD = I_DIV;
        tick();
        instrD = I_ADD;
        tick();
        tick();
        chk("pre_rst", 32'({div_stall, regwriteE, regwriteM}), 32'b111);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst", all_regs(), 32'h0);
        #3;
        rst = 1'b0;
        instrD = 32'h0;
        dc = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (div_stall || div_done) dc++;
        end
        chk("rst_no_resume", 32'(dc), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
